// File: rtl/i2s.sv
// i2s -- I2S master receiver for a 24-bit stereo ADC.
// clk is the ADC master clock at 256 x fs. One free-running 8-bit counter
// produces every timing signal:
//   bck  = cnt[1]    bit clock, clk/4 (64 x fs)
//   lrck = cnt[7]    word select, clk/256 (fs); 0 = left, 1 = right
//   slot = cnt[6:2]  bit slot within the current lrck half (0..31)
// Slot 0 is the I2S one-bit delay after an lrck edge. Slots 1..24 carry the
// 24-bit word MSB first. Slots 25..31 are padding and are ignored.
// Each bit is sampled on the clk edge where cnt[1:0] == 2, in the middle of
// the bck high phase. The last bit (slot 24) is sampled at cnt[6:0] == 98,
// so the word is captured one clk later at cnt[6:0] == 99.
//
// Optional feature (macro I2S_PAIR_ALIGN_EN):
//   When this macro is defined, the left word is first held in an internal
//   register. left and right then update together at cnt == 227, so the two
//   outputs always form a pair from the same frame.
//   When the macro is undefined, left updates at cnt == 99 and right
//   updates at cnt == 227.
// The port list and the reset values are the same in both builds.
//
// There is no valid strobe. left and right simply hold the newest complete
// sample. A consumer may read them at any time and must accept a value that
// is up to one frame old.
`timescale 1ns/1ps

module i2s (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic        bck,
    output logic        lrck,
    output logic        scki,
    output logic [23:0] left,
    output logic [23:0] right
);

    logic [7:0]  cnt;
    logic [23:0] shift;
    logic [4:0]  slot;
    logic        sample_en;
    logic        capture_en;

    assign slot       = cnt[6:2];
    assign sample_en  = (cnt[1:0] == 2'd2) && (slot >= 5'd1) && (slot <= 5'd24);
    assign capture_en = (cnt[6:0] == 7'd99);

    // Clock outputs come straight from counter bits, so they are glitch-free.
    // scki passes clk through untouched, and it keeps running during reset.
    assign bck  = cnt[1];
    assign lrck = cnt[7];
    assign scki = clk;

    // Free-running frame counter; it restarts at left channel, slot 0, after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Shift in data bits from slots 1..24. The register is never cleared
    // between words, because 24 new bits fully overwrite it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift <= 24'd0;
        end else if (sample_en) begin
            shift <= {shift[22:0], din};
        end
    end

`ifdef I2S_PAIR_ALIGN_EN
    logic [23:0] left_hold;

    // Keep the left word until the matching right word arrives, then publish both together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_hold <= 24'd0;
            left      <= 24'd0;
            right     <= 24'd0;
        end else if (capture_en) begin
            if (!cnt[7]) begin
                left_hold <= shift;
            end else begin
                left  <= left_hold;
                right <= shift;
            end
        end
    end
`else
    // Publish each channel one clk after its last bit has been sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left  <= 24'd0;
            right <= 24'd0;
        end else if (capture_en) begin
            if (!cnt[7]) begin
                left <= shift;
            end else begin
                right <= shift;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s.sv
// tb_i2s -- self-checking bench for the i2s receiver.
// The bench keeps its own frame position, counted in clk edges since reset
// release. It models the receiver at the word level: the word sent in a
// half-frame becomes visible at a fixed frame position. Slot timing and
// capture points are written out as plain arithmetic.
// To check the pair-aligned variant, compile with +define+I2S_PAIR_ALIGN_EN.
`timescale 1ns/1ps

module tb_i2s;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        din   = 1'b0;
    logic        bck;
    logic        lrck;
    logic        scki;
    logic [23:0] left;
    logic [23:0] right;

    i2s dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .bck   (bck),
        .lrck  (lrck),
        .scki  (scki),
        .left  (left),
        .right (right)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

`ifdef I2S_PAIR_ALIGN_EN
    localparam int L_CAP = 227;
`else
    localparam int L_CAP = 99;
`endif
    localparam int R_CAP = 227;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // frame_pos = number of clk edges since release, mod 256 (the frame position).
    int          frame_pos = 0;
    logic [23:0] frame_l   = 24'd0;
    logic [23:0] frame_r   = 24'd0;
    logic [23:0] pend_left = 24'd0;
    logic [23:0] exp_left  = 24'd0;
    logic [23:0] exp_right = 24'd0;
    logic [23:0] exp_q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_pos = 0;
            pend_left = 24'd0;
            exp_left  = 24'd0;
            exp_right = 24'd0;
        end else begin
            if (frame_pos == 99)    pend_left = frame_l;
            if (frame_pos == L_CAP) exp_left  = pend_left;
            if (frame_pos == R_CAP) exp_right = frame_r;
            frame_pos = (frame_pos + 1) % 256;
        end
    end

    // ---------------- per-cycle monitor ----------------
    bit mon_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check_val("left_track",  32'(left),  32'(exp_left));
            check_val("right_track", 32'(right), 32'(exp_right));
            check_val("bck_phase",   32'(bck),   32'((frame_pos / 2) % 2));
            check_val("lrck_phase",  32'(lrck),  32'(frame_pos / 128));
            check_val("scki_high",   32'(scki),  32'd1);
        end
    end

    always @(negedge clk) begin
        #1;
        if (mon_en) check_val("scki_low", 32'(scki), 32'd0);
    end

    // ---------------- driver ----------------
    // Drives one full frame. It starts at a negedge where frame_pos == 0 and
    // returns at the first negedge of the next frame.
    // mode selects the filler for slot 0 and slots 25..31:
    //   0 = zeros, 1 = ones, 2 = random.
    task automatic drive_frame(input logic [23:0] lw, input logic [23:0] rw, input int mode);
        int          guard;
        int          slot;
        logic [23:0] w;
        guard = 0;
        while (frame_pos != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (frame_pos != 0) check_val("frame_align_timeout", 32'(frame_pos), 32'd0);
        frame_l = lw;
        frame_r = rw;
        for (int k = 0; k < 256; k++) begin
            slot = (frame_pos / 4) % 32;
            w    = (frame_pos < 128) ? lw : rw;
            if (slot >= 1 && slot <= 24) din = w[24 - slot];
            else if (mode == 0)          din = 1'b0;
            else if (mode == 1)          din = 1'b1;
            else                         din = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    // Records the frame position (the count seen before each edge) at which
    // left and right first change during one frame.
    task automatic watch_changes(output int l_at, output int r_at);
        logic [23:0] pl;
        logic [23:0] pr;
        pl   = left;
        pr   = right;
        l_at = -1;
        r_at = -1;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            if (left !== pl && l_at < 0)  l_at = (frame_pos + 255) % 256;
            if (right !== pr && r_at < 0) r_at = (frame_pos + 255) % 256;
            pl = left;
            pr = right;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [23:0] lw;
        logic [23:0] rw;
        int          mode;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int bck_tog;
        int lrck_tog;
        int bad_gap;
        int last_tog;
        logic pb;
        logic pl;
        int l_at;
        int r_at;
        int n_edges;
        logic [23:0] lw;
        logic [23:0] rw;

        // 0: basic transfer
        // 1: data bits zero, ignored slots high
        // 2: full scale (din held at 1)
        // 3: alternating bit patterns
        // 4: setup for the pair-alignment test
        vecs[0] = '{24'hA5C3F0, 24'h123456, 2, 24'hA5C3F0, 24'h123456};
        vecs[1] = '{24'h000000, 24'h000000, 1, 24'h000000, 24'h000000};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3] = '{24'h5A5A5A, 24'hC3C3C3, 0, 24'h5A5A5A, 24'hC3C3C3};
        vecs[4] = '{24'h7FFFFF, 24'h000000, 2, 24'h7FFFFF, 24'h000000};

        // Reset state: outputs are zero, and scki follows clk during reset.
        #2;
        check_val("rst_left",  32'(left),  32'd0);
        check_val("rst_right", 32'(right), 32'd0);
        check_val("rst_bck",   32'(bck),   32'd0);
        check_val("rst_lrck",  32'(lrck),  32'd0);
        check_val("rst_scki_lo", 32'(scki), 32'd0);
        #5;
        check_val("rst_scki_hi", 32'(scki), 32'd1);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Clock generation over 1024 clk with din idle at 0.
        bck_tog  = 0;
        lrck_tog = 0;
        bad_gap  = 0;
        last_tog = 0;
        pb = bck;
        pl = lrck;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk);
            #1;
            if (bck !== pb) begin
                bck_tog++;
                if (k - last_tog != 2) bad_gap++;
                last_tog = k;
            end
            if (lrck !== pl) lrck_tog++;
            pb = bck;
            pl = lrck;
        end
        check_val("bck_toggles",  32'(bck_tog),  32'd512);
        check_val("bck_gap_errs", 32'(bad_gap),  32'd0);
        check_val("lrck_toggles", 32'(lrck_tog), 32'd8);
        @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            drive_frame(vecs[i].lw, vecs[i].rw, vecs[i].mode);
            check_val($sformatf("vec%0d_left", i),  32'(left),  32'(vecs[i].exp_l));
            check_val($sformatf("vec%0d_right", i), 32'(right), 32'(vecs[i].exp_r));
        end

        // Update instants within one frame (pair alignment when enabled).
        fork
            drive_frame(24'h000001, 24'h800000, 2);
            watch_changes(l_at, r_at);
        join
        check_val("pair_left_edge",  32'(l_at), 32'(L_CAP));
        check_val("pair_right_edge", 32'(r_at), 32'(R_CAP));
        check_val("pair_left",  32'(left),  32'h000001);
        check_val("pair_right", 32'(right), 32'h800000);

        // Randomized frames, checked through the scoreboard queue.
        for (int i = 0; i < 8; i++) begin
            lw = 24'($urandom);
            rw = 24'($urandom);
            exp_q.push_back(lw);
            exp_q.push_back(rw);
            drive_frame(lw, rw, 2);
            check_val("rand_left",  32'(left),  32'(exp_q.pop_front()));
            check_val("rand_right", 32'(right), 32'(exp_q.pop_front()));
        end

        // Reset mid-frame: one full frame, then a partial word cut at cnt=60.
        drive_frame(24'hABCDEF, 24'h654321, 2);
        while (frame_pos != 60) begin
            din = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check_val("midrst_left",  32'(left),  32'd0);
        check_val("midrst_right", 32'(right), 32'd0);
        check_val("midrst_bck",   32'(bck),   32'd0);
        check_val("midrst_lrck",  32'(lrck),  32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n_edges = 0;
        fork
            drive_frame(24'h13579B, 24'h2468AC, 2);
            begin
                while (left === 24'd0 && n_edges < 600) begin
                    @(posedge clk);
                    #1;
                    n_edges++;
                end
            end
        join
        check_val("release_to_left_capture_edges", 32'(n_edges), 32'(L_CAP + 1));
        check_val("post_rst_left",  32'(left),  32'h13579B);
        check_val("post_rst_right", 32'(right), 32'h2468AC);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
